// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl
// Sequencer and configuration controller sitting in front of the FIR filter.
// It keeps a shadow coefficient bank (written freely) and an active bank
// (driven onto the filter taps), forwards a valid/ready sample stream to the
// filter, injects N zero samples on request to flush the delay line, and
// swaps banks atomically while holding the filter in reset. The filter output
// is registered once towards the downstream consumer.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   cfg_we/addr/data   shadow coefficient write (addresses above N ignored)
//   cfg_commit         copy shadow bank to active bank (via SWAP)
//   flush              inject N zero samples into the filter
//   s_data/valid/ready input sample stream
//   fir_din/vin        sample towards the filter
//   fir_b              active bank, tap i at [i*NB +: NB]
//   fir_rst_n          filter reset, active low
//   fir_dout/vout      filter output
//   m_data/valid       registered filter output
//   busy               high whenever the sequencer is not in RUN
//   smp_cnt            accepted input samples, wraps at 2^16
module fir_seq_ctrl #(
  parameter int NB = 12,
  parameter int N  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [NB-1:0]       cfg_data,
  input  logic                cfg_commit,
  input  logic                flush,
  input  logic [NB-1:0]       s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [NB-1:0]       fir_din,
  output logic                fir_vin,
  output logic [(N+1)*NB-1:0] fir_b,
  output logic                fir_rst_n,
  input  logic [NB-1:0]       fir_dout,
  input  logic                fir_vout,
  output logic [NB-1:0]       m_data,
  output logic                m_valid,
  output logic                busy,
  output logic [15:0]         smp_cnt
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_SWAP  = 2'd3;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [CW-1:0] flush_cnt;
  logic          pending;
  logic [NB-1:0] shadow [N+1];
  logic [NB-1:0] active [N+1];

  // The handshake is gated by rst so that s_ready is already low in the
  // reset cycle itself, before the state register has returned to INIT.
  always_comb begin
    s_ready = (state == ST_RUN) && !rst;
    busy    = (state != ST_RUN) || rst;
  end

  // Flatten the active bank onto the filter tap bus.
  always_comb begin
    fir_b = '0;
    for (int i = 0; i <= N; i++) begin
      fir_b[i*NB +: NB] = active[i];
    end
  end

  // Main sequencer. Shadow writes and the output register run in every
  // state; the bank copy in SWAP reads the shadow value from before this
  // edge, so a write landing in the SWAP cycle misses the current copy.
  // A commit arriving on the last flush cycle is honoured directly rather
  // than through the pending flag, since SWAP clears that flag anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      flush_cnt <= '0;
      pending   <= 1'b0;
      fir_din   <= '0;
      fir_vin   <= 1'b0;
      fir_rst_n <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      smp_cnt   <= '0;
      for (int i = 0; i <= N; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (cfg_we && (int'(cfg_addr) <= N)) begin
        shadow[cfg_addr] <= cfg_data;
      end

      m_valid <= fir_vout & fir_rst_n;
      if (fir_vout) begin
        m_data <= fir_dout;
      end

      case (state)
        ST_INIT: begin
          fir_rst_n <= 1'b1;
          fir_vin   <= 1'b0;
          state     <= ST_RUN;
        end

        ST_RUN: begin
          fir_rst_n <= 1'b1;
          if (s_valid) begin
            fir_din <= s_data;
            fir_vin <= 1'b1;
            smp_cnt <= smp_cnt + 16'd1;
          end else begin
            fir_vin <= 1'b0;
          end
          if (cfg_commit) begin
            state <= ST_SWAP;
          end else if (flush) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end
        end

        ST_FLUSH: begin
          fir_vin <= 1'b1;
          fir_din <= '0;
          if (flush_cnt == CNT_LAST) begin
            flush_cnt <= '0;
            state     <= (pending || cfg_commit) ? ST_SWAP : ST_RUN;
          end else begin
            flush_cnt <= flush_cnt + CW'(1);
            if (cfg_commit) begin
              pending <= 1'b1;
            end
          end
        end

        ST_SWAP: begin
          for (int i = 0; i <= N; i++) begin
            active[i] <= shadow[i];
          end
          fir_rst_n <= 1'b0;
          fir_vin   <= 1'b0;
          pending   <= 1'b0;
          state     <= ST_RUN;
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl
// Self-checking bench for fir_seq_ctrl. A timeline model tracks, by cycle
// number, when the controller is accepting samples, which cycles carry
// injected zeros, when the bank swap happens and when the filter reset
// pulses; every scenario task compares the DUT against that model and
// against the scenario's own fixed expectations.
module tb_fir_seq_ctrl;

  localparam int NB = 12;
  localparam int N  = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_we;
  logic [3:0]          cfg_addr;
  logic [NB-1:0]       cfg_data;
  logic                cfg_commit;
  logic                flush;
  logic [NB-1:0]       s_data;
  logic                s_valid;
  logic                s_ready;
  logic [NB-1:0]       fir_din;
  logic                fir_vin;
  logic [(N+1)*NB-1:0] fir_b;
  logic                fir_rst_n;
  logic [NB-1:0]       fir_dout;
  logic                fir_vout;
  logic [NB-1:0]       m_data;
  logic                m_valid;
  logic                busy;
  logic [15:0]         smp_cnt;

  fir_seq_ctrl #(.NB(NB), .N(N)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fir_din(fir_din), .fir_vin(fir_vin), .fir_b(fir_b), .fir_rst_n(fir_rst_n),
    .fir_dout(fir_dout), .fir_vout(fir_vout),
    .m_data(m_data), .m_valid(m_valid), .busy(busy), .smp_cnt(smp_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Timeline model: cycles are labelled by the edge that starts them.
  int            cyc      = 0;
  int            run_from = 1 << 30;
  int            flush_lo = -100;
  int            flush_hi = -100;
  int            swap_cyc = -100;
  bit            pend     = 1'b0;
  logic [NB-1:0] shadow_m [N+1];
  logic [NB-1:0] bank_m   [N+1];
  logic [NB-1:0] e_din, e_mdata;
  logic          e_vin, e_rstn, e_mvalid;
  logic [15:0]   e_cnt;
  logic          obs_ready, obs_busy, obs_rstn, x_ready, x_busy;

  int coef [N+1] = '{-1, -7, -13, 32, 140, 203, 140, 32, -13, -7, -1};
  int stream_init [6] = '{-159, 0, -415, 0, -512, -1};

  function automatic logic [(N+1)*NB-1:0] model_bank();
    logic [(N+1)*NB-1:0] r;
    for (int i = 0; i <= N; i++) r[i*NB +: NB] = bank_m[i];
    return r;
  endfunction

  function automatic logic [(N+1)*NB-1:0] coef_word();
    logic [(N+1)*NB-1:0] r;
    for (int i = 0; i <= N; i++) r[i*NB +: NB] = NB'(coef[i]);
    return r;
  endfunction

  // Advance the model across the coming edge using the inputs of this cycle.
  task automatic model_update();
    int k;
    bit ready_c, in_fl;
    k = cyc + 1;
    if (rst) begin
      for (int i = 0; i <= N; i++) begin
        shadow_m[i] = '0;
        bank_m[i]   = '0;
      end
      e_din = '0; e_vin = 1'b0; e_rstn = 1'b0; e_mdata = '0; e_mvalid = 1'b0; e_cnt = '0;
      run_from = k + 1;
      flush_lo = -100; flush_hi = -100; swap_cyc = -100; pend = 1'b0;
    end else begin
      ready_c  = (cyc >= run_from);
      in_fl    = (cyc >= flush_lo) && (cyc <= flush_hi);
      e_mvalid = fir_vout & e_rstn;
      if (fir_vout) e_mdata = fir_dout;
      e_rstn = 1'b1;
      e_vin  = 1'b0;
      if (cyc == swap_cyc) begin
        bank_m = shadow_m;
        e_rstn = 1'b0;
        pend   = 1'b0;
      end
      if (in_fl) begin
        e_vin = 1'b1;
        e_din = '0;
        if (cfg_commit) pend = 1'b1;
        if (cyc == flush_hi && pend) begin
          swap_cyc = k;
          run_from = k + 1;
        end
      end
      if (ready_c) begin
        if (s_valid) begin
          e_vin = 1'b1;
          e_din = s_data;
          e_cnt = e_cnt + 16'd1;
        end
        if (cfg_commit) begin
          swap_cyc = k;
          run_from = k + 1;
        end else if (flush) begin
          flush_lo = k;
          flush_hi = k + N - 1;
          run_from = k + N;
        end
      end
      if (cfg_we && cfg_addr <= N) shadow_m[cfg_addr] = cfg_data;
    end
  endtask

  // One clock: sample combinational outputs of the current cycle, update the
  // model, cross the edge and settle just after it.
  task automatic step();
    fir_vout = 1'($urandom_range(0, 1));
    fir_dout = NB'($urandom);
    #1;
    obs_ready = s_ready;
    obs_busy  = busy;
    obs_rstn  = fir_rst_n;
    x_ready   = !rst && (cyc >= run_from);
    x_busy    = rst || (cyc < run_from);
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_commit = 1'b0; flush = 1'b0; s_data = '0; s_valid = 1'b0;
  endtask

  task automatic test_reset();
    int rst_low = 0, first_nb = -1, first_rdy = -1;
    idle();
    for (int i = 0; i < 7; i++) begin
      rst = (i < 3);
      step();
      checks++;
      if (obs_ready !== x_ready || obs_busy !== x_busy) begin
        errors++;
        $display("[TB] FAIL reset_hs cyc=%0d got ready=%b busy=%b want ready=%b busy=%b", cyc-1, obs_ready, obs_busy, x_ready, x_busy);
      end
      checks++;
      if (fir_vin !== e_vin || fir_din !== e_din || fir_rst_n !== e_rstn || fir_b !== model_bank()) begin
        errors++;
        $display("[TB] FAIL reset_fir cyc=%0d got vin=%b din=%h rst_n=%b b=%h want vin=%b din=%h rst_n=%b b=%h", cyc, fir_vin, fir_din, fir_rst_n, fir_b, e_vin, e_din, e_rstn, model_bank());
      end
      checks++;
      if (m_valid !== e_mvalid || m_data !== e_mdata || smp_cnt !== e_cnt) begin
        errors++;
        $display("[TB] FAIL reset_out cyc=%0d got mv=%b md=%h cnt=%0d want mv=%b md=%h cnt=%0d", cyc, m_valid, m_data, smp_cnt, e_mvalid, e_mdata, e_cnt);
      end
      if (i >= 3) begin
        if (obs_rstn === 1'b0) rst_low++;
        if (obs_busy === 1'b0 && first_nb < 0) first_nb = i;
        if (obs_ready === 1'b1 && first_rdy < 0) first_rdy = i;
      end
    end
    checks++;
    if (rst_low != 1 || first_nb != 4 || first_rdy != 4) begin
      errors++;
      $display("[TB] FAIL reset_init got rst_n_low=%0d busy_fall=%0d ready_rise=%0d want 1 4 4", rst_low, first_nb, first_rdy);
    end
  endtask

  task automatic test_coeff_load();
    int rst_low = 0;
    idle();
    for (int i = 0; i < 20; i++) begin
      cfg_we     = (i < 13);
      cfg_addr   = (i == 11) ? 4'd12 : (i == 12) ? 4'd15 : 4'(i);
      cfg_data   = (i < 11) ? NB'(coef[i]) : NB'($urandom);
      cfg_commit = (i == 13);
      step();
      checks++;
      if (obs_ready !== x_ready || obs_busy !== x_busy) begin
        errors++;
        $display("[TB] FAIL coeff_hs cyc=%0d got ready=%b busy=%b want ready=%b busy=%b", cyc-1, obs_ready, obs_busy, x_ready, x_busy);
      end
      checks++;
      if (fir_vin !== e_vin || fir_din !== e_din || fir_rst_n !== e_rstn || fir_b !== model_bank()) begin
        errors++;
        $display("[TB] FAIL coeff_fir cyc=%0d got vin=%b din=%h rst_n=%b b=%h want vin=%b din=%h rst_n=%b b=%h", cyc, fir_vin, fir_din, fir_rst_n, fir_b, e_vin, e_din, e_rstn, model_bank());
      end
      checks++;
      if (m_valid !== e_mvalid || m_data !== e_mdata || smp_cnt !== e_cnt) begin
        errors++;
        $display("[TB] FAIL coeff_out cyc=%0d got mv=%b md=%h cnt=%0d want mv=%b md=%h cnt=%0d", cyc, m_valid, m_data, smp_cnt, e_mvalid, e_mdata, e_cnt);
      end
      if (i >= 13 && fir_rst_n === 1'b0) rst_low++;
      if (i == 13) begin
        checks++;
        if (fir_b !== '0) begin
          errors++;
          $display("[TB] FAIL coeff_early got b=%h want 0", fir_b);
        end
      end
      if (i == 14) begin
        checks++;
        if (fir_b !== coef_word() || fir_rst_n !== 1'b0) begin
          errors++;
          $display("[TB] FAIL coeff_apply got b=%h rst_n=%b want b=%h rst_n=0", fir_b, fir_rst_n, coef_word());
        end
      end
    end
    checks++;
    if (rst_low != 1 || fir_b !== coef_word()) begin
      errors++;
      $display("[TB] FAIL coeff_final got rst_n_low=%0d b=%h want 1 b=%h", rst_low, fir_b, coef_word());
    end
  endtask

  task automatic test_streaming();
    logic [NB-1:0] sent[$], recv[$];
    bit ok;
    idle();
    for (int i = 0; i < 33; i++) begin
      s_valid = (i < 30) && (i % 3 != 2);
      s_data  = (sent.size() < 6) ? NB'(stream_init[sent.size()]) : NB'($urandom);
      step();
      if (obs_ready && s_valid) sent.push_back(s_data);
      if (fir_vin === 1'b1) recv.push_back(fir_din);
      checks++;
      if (obs_ready !== x_ready || obs_busy !== x_busy) begin
        errors++;
        $display("[TB] FAIL stream_hs cyc=%0d got ready=%b busy=%b want ready=%b busy=%b", cyc-1, obs_ready, obs_busy, x_ready, x_busy);
      end
      checks++;
      if (fir_vin !== e_vin || fir_din !== e_din || fir_rst_n !== e_rstn || fir_b !== model_bank()) begin
        errors++;
        $display("[TB] FAIL stream_fir cyc=%0d got vin=%b din=%h rst_n=%b b=%h want vin=%b din=%h rst_n=%b b=%h", cyc, fir_vin, fir_din, fir_rst_n, fir_b, e_vin, e_din, e_rstn, model_bank());
      end
      checks++;
      if (m_valid !== e_mvalid || m_data !== e_mdata || smp_cnt !== e_cnt) begin
        errors++;
        $display("[TB] FAIL stream_out cyc=%0d got mv=%b md=%h cnt=%0d want mv=%b md=%h cnt=%0d", cyc, m_valid, m_data, smp_cnt, e_mvalid, e_mdata, e_cnt);
      end
    end
    ok = (sent.size() == 20) && (recv.size() == 20);
    for (int i = 0; ok && i < 20; i++) if (recv[i] !== sent[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL stream_order got sent=%0d recv=%0d want 20 identical samples", sent.size(), recv.size());
    end
    checks++;
    if (smp_cnt !== 16'd20) begin
      errors++;
      $display("[TB] FAIL stream_cnt got %0d want 20", smp_cnt);
    end
  endtask

  task automatic test_flush();
    int zeros = 0, ready_low = 0;
    bit took158 = 1'b0;
    idle();
    for (int i = 0; i < 19; i++) begin
      s_valid = 1'b1;
      flush   = (i == 3);
      s_data  = (i >= 4 && !took158) ? NB'(158) : NB'($urandom_range(1, 4095));
      step();
      if (i >= 4 && obs_ready) took158 = 1'b1;
      if (obs_ready === 1'b0) ready_low++;
      if (fir_vin === 1'b1 && fir_din === '0) zeros++;
      checks++;
      if (obs_ready !== x_ready || obs_busy !== x_busy) begin
        errors++;
        $display("[TB] FAIL flush_hs cyc=%0d got ready=%b busy=%b want ready=%b busy=%b", cyc-1, obs_ready, obs_busy, x_ready, x_busy);
      end
      checks++;
      if (fir_vin !== e_vin || fir_din !== e_din || fir_rst_n !== e_rstn || fir_b !== model_bank()) begin
        errors++;
        $display("[TB] FAIL flush_fir cyc=%0d got vin=%b din=%h rst_n=%b b=%h want vin=%b din=%h rst_n=%b b=%h", cyc, fir_vin, fir_din, fir_rst_n, fir_b, e_vin, e_din, e_rstn, model_bank());
      end
      checks++;
      if (m_valid !== e_mvalid || m_data !== e_mdata || smp_cnt !== e_cnt) begin
        errors++;
        $display("[TB] FAIL flush_out cyc=%0d got mv=%b md=%h cnt=%0d want mv=%b md=%h cnt=%0d", cyc, m_valid, m_data, smp_cnt, e_mvalid, e_mdata, e_cnt);
      end
      if (i == 14) begin
        checks++;
        if (fir_vin !== 1'b1 || fir_din !== NB'(158)) begin
          errors++;
          $display("[TB] FAIL flush_resume got vin=%b din=%0d want vin=1 din=158", fir_vin, fir_din);
        end
      end
    end
    checks++;
    if (zeros != 10 || ready_low != 10) begin
      errors++;
      $display("[TB] FAIL flush_len got zeros=%0d ready_low=%0d want 10 10", zeros, ready_low);
    end
  endtask

  task automatic test_collision();
    int a_vin = 0, a_low = 0, a_busy = 0, b_zero = 0, b_low = 0, b_low_at = -1, b_busy = 0;
    idle();
    for (int i = 0; i < 41; i++) begin
      idle();
      flush      = (i == 0) || (i == 24);
      cfg_commit = (i == 0) || (i == 29);
      if (i >= 13 && i <= 23) begin
        cfg_we   = 1'b1;
        cfg_addr = 4'(i - 13);
        cfg_data = (i == 13) ? 12'h0AA : NB'($urandom);
      end
      if (i == 35) begin
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 12'h123;
      end
      step();
      if (i <= 12) begin
        if (fir_vin === 1'b1) a_vin++;
        if (fir_rst_n === 1'b0) a_low++;
        if (obs_busy === 1'b1) a_busy++;
      end else if (i >= 24) begin
        if (fir_vin === 1'b1 && fir_din === '0) b_zero++;
        if (fir_rst_n === 1'b0) begin b_low++; b_low_at = i; end
        if (obs_busy === 1'b1) b_busy++;
      end
      checks++;
      if (obs_ready !== x_ready || obs_busy !== x_busy) begin
        errors++;
        $display("[TB] FAIL coll_hs cyc=%0d got ready=%b busy=%b want ready=%b busy=%b", cyc-1, obs_ready, obs_busy, x_ready, x_busy);
      end
      checks++;
      if (fir_vin !== e_vin || fir_din !== e_din || fir_rst_n !== e_rstn || fir_b !== model_bank()) begin
        errors++;
        $display("[TB] FAIL coll_fir cyc=%0d got vin=%b din=%h rst_n=%b b=%h want vin=%b din=%h rst_n=%b b=%h", cyc, fir_vin, fir_din, fir_rst_n, fir_b, e_vin, e_din, e_rstn, model_bank());
      end
      checks++;
      if (m_valid !== e_mvalid || m_data !== e_mdata || smp_cnt !== e_cnt) begin
        errors++;
        $display("[TB] FAIL coll_out cyc=%0d got mv=%b md=%h cnt=%0d want mv=%b md=%h cnt=%0d", cyc, m_valid, m_data, smp_cnt, e_mvalid, e_mdata, e_cnt);
      end
    end
    checks++;
    if (a_vin != 0 || a_low != 1 || a_busy != 1) begin
      errors++;
      $display("[TB] FAIL coll_same got vin=%0d rst_n_low=%0d busy=%0d want 0 1 1", a_vin, a_low, a_busy);
    end
    checks++;
    if (b_zero != 10 || b_low != 1 || b_low_at != 35 || b_busy != 11) begin
      errors++;
      $display("[TB] FAIL coll_pending got zeros=%0d rst_n_low=%0d at=%0d busy=%0d want 10 1 35 11", b_zero, b_low, b_low_at, b_busy);
    end
    checks++;
    if (fir_b[NB-1:0] !== 12'h0AA) begin
      errors++;
      $display("[TB] FAIL coll_swap_write got tap0=%h want 0aa", fir_b[NB-1:0]);
    end
  endtask

  task automatic test_reset_mid();
    int vins = 0;
    idle();
    for (int i = 0; i < 23; i++) begin
      flush = (i == 0);
      rst   = (i == 6);
      step();
      if (i == 6) begin
        checks++;
        if (fir_vin !== 1'b0 || fir_din !== '0 || fir_rst_n !== 1'b0 || fir_b !== '0 ||
            m_valid !== 1'b0 || m_data !== '0 || smp_cnt !== '0 || s_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL midrst_vals got vin=%b din=%h rst_n=%b b=%h mv=%b md=%h cnt=%0d ready=%b busy=%b want all 0 busy=1", fir_vin, fir_din, fir_rst_n, fir_b, m_valid, m_data, smp_cnt, s_ready, busy);
        end
      end
      if (i > 6 && fir_vin === 1'b1) vins++;
      checks++;
      if (obs_ready !== x_ready || obs_busy !== x_busy) begin
        errors++;
        $display("[TB] FAIL midrst_hs cyc=%0d got ready=%b busy=%b want ready=%b busy=%b", cyc-1, obs_ready, obs_busy, x_ready, x_busy);
      end
      checks++;
      if (fir_vin !== e_vin || fir_din !== e_din || fir_rst_n !== e_rstn || fir_b !== model_bank()) begin
        errors++;
        $display("[TB] FAIL midrst_fir cyc=%0d got vin=%b din=%h rst_n=%b b=%h want vin=%b din=%h rst_n=%b b=%h", cyc, fir_vin, fir_din, fir_rst_n, fir_b, e_vin, e_din, e_rstn, model_bank());
      end
      checks++;
      if (m_valid !== e_mvalid || m_data !== e_mdata || smp_cnt !== e_cnt) begin
        errors++;
        $display("[TB] FAIL midrst_out cyc=%0d got mv=%b md=%h cnt=%0d want mv=%b md=%h cnt=%0d", cyc, m_valid, m_data, smp_cnt, e_mvalid, e_mdata, e_cnt);
      end
    end
    checks++;
    if (vins != 0) begin
      errors++;
      $display("[TB] FAIL midrst_noresume got vin_cycles=%0d want 0", vins);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      cfg_we     = ($urandom_range(0, 2) == 0);
      cfg_addr   = 4'($urandom);
      cfg_data   = NB'($urandom);
      cfg_commit = ($urandom_range(0, 14) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      s_valid    = 1'($urandom_range(0, 1));
      s_data     = NB'($urandom);
      step();
      checks++;
      if (obs_ready !== x_ready || obs_busy !== x_busy) begin
        errors++;
        $display("[TB] FAIL rand_hs cyc=%0d got ready=%b busy=%b want ready=%b busy=%b", cyc-1, obs_ready, obs_busy, x_ready, x_busy);
      end
      checks++;
      if (fir_vin !== e_vin || fir_din !== e_din || fir_rst_n !== e_rstn || fir_b !== model_bank()) begin
        errors++;
        $display("[TB] FAIL rand_fir cyc=%0d got vin=%b din=%h rst_n=%b b=%h want vin=%b din=%h rst_n=%b b=%h", cyc, fir_vin, fir_din, fir_rst_n, fir_b, e_vin, e_din, e_rstn, model_bank());
      end
      checks++;
      if (m_valid !== e_mvalid || m_data !== e_mdata || smp_cnt !== e_cnt) begin
        errors++;
        $display("[TB] FAIL rand_out cyc=%0d got mv=%b md=%h cnt=%0d want mv=%b md=%h cnt=%0d", cyc, m_valid, m_data, smp_cnt, e_mvalid, e_mdata, e_cnt);
      end
    end
  endtask

  initial begin
    idle();
    fir_vout = 1'b0;
    fir_dout = '0;
    test_reset();
    test_coeff_load();
    test_streaming();
    test_flush();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
